beat_sequencer: RTL and testbench
=================================

Name: beat_sequencer

Overview:
- Sits directly downstream of the play/pause toggle controller and consumes its play_or_pause level.
- While playing, it divides clk into beat periods at a selectable tempo and advances a beat index, which addresses the tone ROM and the display stage.
- Handles pause/resume without losing position, restart, loop or stop-at-end, and end-of-song signalling.

Parameters:
- BEAT_CYCLES, 12_500_000, clk cycles per beat at normal speed; must be even and >= 4.
- SONG_LEN, 512, number of beats in the song; must be >= 2.
- BEAT_W, 9, width of beat_idx; SONG_LEN <= 2**BEAT_W.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- play_or_pause  input  1  level from play/pause controller; 1 = play, 0 = pause
- restart_1p  input  1  one-cycle pulse; return to beat 0
- loop_en  input  1  1 = wrap to beat 0 after last beat; 0 = stop at end
- speed  input  2  0 = half speed, 1 = normal, 2 = double, 3 = normal
- beat_idx  output  BEAT_W  current beat, 0..SONG_LEN-1
- beat_tick  output  1  one-cycle pulse on every beat boundary
- song_done  output  1  one-cycle pulse when the last beat completes
- state  output  2  0 = IDLE, 1 = PLAY, 2 = PAUSE, 3 = DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, beat_idx=0, internal cycle counter cnt=0, beat_tick=0, song_done=0. All outputs are registered.
- Period P, selected by the current speed each cycle:
  - speed 0: P = 2*BEAT_CYCLES
  - speed 1 or 3: P = BEAT_CYCLES
  - speed 2: P = BEAT_CYCLES/2
  - cnt width is wide enough for 2*BEAT_CYCLES-1.
- State transitions:
  - IDLE: cnt=0, beat_idx=0. play_or_pause=1 -> PLAY next cycle.
  - PLAY: cnt increments each cycle.
  - PLAY, when cnt >= P-1 (beat boundary): cnt<=0; beat_tick=1 on the next cycle.
    - If beat_idx < SONG_LEN-1: beat_idx+1.
    - Else, loop_en=1: beat_idx<=0, song_done pulse, stay PLAY.
    - Else, loop_en=0: beat_idx holds at SONG_LEN-1, song_done pulse, -> DONE.
  - PLAY, play_or_pause=0 -> PAUSE. cnt and beat_idx freeze; a boundary in that same cycle is not taken.
  - PAUSE: holds cnt and beat_idx. play_or_pause=1 -> PLAY, resuming from the frozen cnt.
  - DONE: holds beat_idx; no ticks. play_or_pause=0 -> IDLE with beat_idx<=0, cnt<=0.
- The >= compare means a speed change that shrinks P below cnt+1 forces a boundary on the next cycle. No skipped beats, no counter overrun.
- restart_1p has priority over every other event in the same cycle:
  - Sets beat_idx<=0 and cnt<=0, with no beat_tick and no song_done.
  - From PLAY: stays PLAY.
  - From PAUSE, IDLE or DONE: -> IDLE if play_or_pause=0, -> PLAY if play_or_pause=1.
- beat_tick and song_done are asserted for exactly one cycle per event. They never assert in IDLE, PAUSE or DONE, except the completing pulse of the transition into DONE.
- beat_idx never exceeds SONG_LEN-1.
- Reset asserted mid-operation returns to the reset values immediately, independent of clk.

Test Plan (BEAT_CYCLES=4, SONG_LEN=4, BEAT_W=2):
1. Reset: rst pulse with play_or_pause=0 -> state=0, beat_idx=0, beat_tick=0, song_done=0; hold 20 cycles -> no change.
2. Normal stop: play_or_pause=1, speed=1, loop_en=0 -> state=1.
   - beat_tick every 4 cycles; beat_idx 1,2,3.
   - 4th boundary -> song_done pulse, beat_idx=3, state=3.
   - Drop play_or_pause -> state=0, beat_idx=0.
3. Loop and pause: loop_en=1 -> after beat 3, beat_idx=0 with song_done pulse, state stays 1.
   - Drop play_or_pause at cnt=2 for 10 cycles -> beat_idx frozen, no ticks.
   - Resume -> next tick after exactly 2 more cycles.
4. Speed: speed=0 -> ticks every 8 cycles; speed=2 -> every 2 cycles.
   - Switch speed 0->2 while cnt=5 -> tick on the next cycle, then every 2 cycles.
5. Restart collision: restart_1p in the same cycle as a beat boundary at beat_idx=2 -> beat_idx=0, no beat_tick, state stays 1.
   - restart_1p while in state 2 with play_or_pause=0 -> state=0.
6. Async reset mid-song: assert rst between clk edges at beat_idx=2 -> outputs reach reset values before the next clk edge; release -> IDLE.

Source files
------------

// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
//
// Divides clk into beat periods at a selectable tempo and advances a beat
// index while the upstream play/pause controller reports "play". Keeps its
// position across pause/resume. Supports restart, loop-or-stop at the end of
// the song, and a one-cycle end-of-song pulse.
//
// Parameters
//   BEAT_CYCLES  clk cycles per beat at normal speed (even, >= 4)
//   SONG_LEN     beats in the song (>= 2)
//   BEAT_W       width of beat_idx (SONG_LEN <= 2**BEAT_W)
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   play_or_pause  in   1 = play, 0 = pause (level)
//   restart_1p     in   one-cycle pulse: return to beat 0 (highest priority)
//   loop_en        in   1 = wrap to beat 0 after the last beat, 0 = stop
//   speed[1:0]     in   0 = half, 1 = normal, 2 = double, 3 = normal
//   beat_idx       out  current beat, 0..SONG_LEN-1 (registered)
//   beat_tick      out  one-cycle pulse per beat boundary (registered)
//   song_done      out  one-cycle pulse when the last beat completes
//   state[1:0]     out  0 = IDLE, 1 = PLAY, 2 = PAUSE, 3 = DONE
// -----------------------------------------------------------------------------
module beat_sequencer #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int SONG_LEN    = 512,
  parameter int BEAT_W      = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_or_pause,
  input  logic              restart_1p,
  input  logic              loop_en,
  input  logic [1:0]        speed,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              beat_tick,
  output logic              song_done,
  output logic [1:0]        state
);

  // Counter must hold up to 2*BEAT_CYCLES-1 (the half-speed period).
  localparam int CNT_W = $clog2(2 * BEAT_CYCLES);

  // Terminal counts (period minus one) so the compare never needs a value
  // that would not fit in the counter width.
  localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(2 * BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  NORMAL_M1 = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DOUBLE_M1 = CNT_W'(BEAT_CYCLES / 2 - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [BEAT_W-1:0]  idx_q,     idx_d;
  logic               tick_q,    tick_d;
  logic               done_q,    done_d;
  logic [CNT_W-1:0]   period_m1;

  // Period follows the live speed input every cycle.
  always_comb begin
    case (speed)
      2'd0:    period_m1 = HALF_M1;
      2'd2:    period_m1 = DOUBLE_M1;
      default: period_m1 = NORMAL_M1;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (restart_1p) begin
      // Restart wins over boundaries, pause and end-of-song in this cycle.
      cnt_d = '0;
      idx_d = '0;
      if (state_q != PLAY) begin
        state_d = play_or_pause ? PLAY : IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          idx_d = '0;
          if (play_or_pause) state_d = PLAY;
        end

        PLAY: begin
          if (!play_or_pause) begin
            // Freeze position; a boundary due this cycle waits for resume.
            state_d = PAUSE;
          end else if (cnt_q >= period_m1) begin
            // ">=" rather than "==" so a speed change that shrinks the
            // period below the current count ends the beat immediately.
            cnt_d  = '0;
            tick_d = 1'b1;
            if (idx_q < LAST_BEAT) begin
              idx_d = idx_q + BEAT_W'(1);
            end else begin
              done_d = 1'b1;
              if (loop_en) idx_d   = '0;
              else         state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        PAUSE: begin
          if (play_or_pause) state_d = PLAY;
        end

        DONE: begin
          if (!play_or_pause) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign beat_idx  = idx_q;
  assign beat_tick = tick_q;
  assign song_done = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beat_sequencer
//
// Self-checking bench for beat_sequencer (BEAT_CYCLES=4, SONG_LEN=4,
// BEAT_W=2). A behavioural model tracks play mode, song position and time
// elapsed in the current beat as plain integers and is compared with the DUT
// after every clock edge. Directed phases also measure tick spacing against
// fixed expected intervals, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_beat_sequencer;

  localparam int BC = 4;
  localparam int SL = 4;
  localparam int BW = 2;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          play_or_pause;
  logic          restart_1p;
  logic          loop_en;
  logic [1:0]    speed;
  logic [BW-1:0] beat_idx;
  logic          beat_tick;
  logic          song_done;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode, beat position, cycles spent in the current beat.
  int m_mode, m_pos, m_elapsed, m_tick, m_done;

  always #5 clk = ~clk;

  beat_sequencer #(
    .BEAT_CYCLES(BC),
    .SONG_LEN   (SL),
    .BEAT_W     (BW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .play_or_pause(play_or_pause),
    .restart_1p   (restart_1p),
    .loop_en      (loop_en),
    .speed        (speed),
    .beat_idx     (beat_idx),
    .beat_tick    (beat_tick),
    .song_done    (song_done),
    .state        (state)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_pos     = 0;
    m_elapsed = 0;
    m_tick    = 0;
    m_done    = 0;
  endtask

  // Beat length in cycles for a given tempo selection.
  function automatic int beat_len(input logic [1:0] spd);
    if (spd == 2'd0)      return 2 * BC;
    else if (spd == 2'd2) return BC / 2;
    else                  return BC;
  endfunction

  // One clock edge of the specified behaviour, using the inputs as they
  // stood before the edge.
  task automatic model_step();
    m_tick = 0;
    m_done = 0;
    if (restart_1p) begin
      m_pos     = 0;
      m_elapsed = 0;
      if (m_mode != M_PLAY) m_mode = play_or_pause ? M_PLAY : M_IDLE;
    end else if (m_mode == M_IDLE) begin
      m_pos     = 0;
      m_elapsed = 0;
      if (play_or_pause) m_mode = M_PLAY;
    end else if (m_mode == M_PLAY) begin
      if (!play_or_pause) begin
        m_mode = M_PAUSE;
      end else if (m_elapsed + 1 >= beat_len(speed)) begin
        m_elapsed = 0;
        m_tick    = 1;
        if (m_pos < SL - 1) begin
          m_pos++;
        end else begin
          m_done = 1;
          if (loop_en) m_pos  = 0;
          else         m_mode = M_DONE;
        end
      end else begin
        m_elapsed++;
      end
    end else if (m_mode == M_PAUSE) begin
      if (play_or_pause) m_mode = M_PLAY;
    end else begin
      if (!play_or_pause) begin
        m_mode    = M_IDLE;
        m_pos     = 0;
        m_elapsed = 0;
      end
    end
  endtask

  task automatic compare_model();
    check("state",     state,     m_mode);
    check("beat_idx",  beat_idx,  m_pos);
    check("beat_tick", beat_tick, m_tick);
    check("song_done", song_done, m_done);
  endtask

  // Advance one clock: model and DUT both step, outputs sampled 1 time unit
  // after the edge; inputs may then change safely.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Clock until beat_tick is seen (bounded); returns the cycles taken.
  task automatic wait_tick(input int max_cycles, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (beat_tick !== 1'b1 && n < max_cycles);
    if (beat_tick !== 1'b1) check("tick_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int ticks;

    // ---- 1. reset ----
    rst           = 1'b1;
    play_or_pause = 1'b0;
    restart_1p    = 1'b0;
    loop_en       = 1'b0;
    speed         = 2'd1;
    model_reset();
    #3;
    compare_model();
    @(negedge clk);
    rst = 1'b0;
    run(20);
    check("idle_hold_state", state, M_IDLE);

    // ---- 2. normal play, stop at end ----
    play_or_pause = 1'b1;
    tick();
    check("enter_play", state, M_PLAY);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(20, n);
      check("stop_interval", n, 4);
      check("stop_idx", beat_idx, k);
    end
    wait_tick(20, n);
    check("last_interval", n, 4);
    check("last_done", song_done, 1);
    check("last_idx", beat_idx, SL - 1);
    check("last_state", state, M_DONE);
    run(5);
    check("done_hold_idx", beat_idx, SL - 1);
    play_or_pause = 1'b0;
    tick();
    check("done_to_idle", state, M_IDLE);
    check("done_idx_clear", beat_idx, 0);

    // ---- 3. loop and pause ----
    loop_en       = 1'b1;
    play_or_pause = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) wait_tick(20, n);
    check("wrap_idx", beat_idx, 0);
    check("wrap_done", song_done, 1);
    check("wrap_state", state, M_PLAY);
    run(2);                       // count now at 2
    play_or_pause = 1'b0;
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (beat_tick === 1'b1) ticks++;
    end
    check("pause_ticks", ticks, 0);
    check("pause_idx", beat_idx, 0);
    check("pause_state", state, M_PAUSE);
    play_or_pause = 1'b1;
    tick();
    check("resume_state", state, M_PLAY);
    wait_tick(20, n);
    check("resume_interval", n, 2);

    // ---- 4. tempo ----
    speed = 2'd0;
    wait_tick(40, n);
    check("half_interval_a", n, 8);
    wait_tick(40, n);
    check("half_interval_b", n, 8);
    speed = 2'd2;
    wait_tick(40, n);
    check("double_interval_a", n, 2);
    wait_tick(40, n);
    check("double_interval_b", n, 2);
    speed = 2'd0;
    wait_tick(40, n);
    run(5);                       // count now at 5
    speed = 2'd2;
    wait_tick(40, n);
    check("shrink_forced", n, 1);
    wait_tick(40, n);
    check("shrink_after", n, 2);

    // ---- 5. restart collisions ----
    speed = 2'd1;
    n = 0;
    while (beat_idx !== BW'(2) && n < 50) begin
      tick();
      n++;
    end
    check("reach_idx2", beat_idx, 2);
    wait_tick(20, n);              // resync: boundary just taken
    while (beat_idx !== BW'(2)) wait_tick(20, n);
    run(3);                        // boundary due on the next edge
    restart_1p = 1'b1;
    tick();
    restart_1p = 1'b0;
    check("rst_coll_idx", beat_idx, 0);
    check("rst_coll_tick", beat_tick, 0);
    check("rst_coll_state", state, M_PLAY);
    wait_tick(20, n);
    check("rst_coll_interval", n, 4);
    play_or_pause = 1'b0;
    tick();
    check("pause_again", state, M_PAUSE);
    restart_1p = 1'b1;
    tick();
    restart_1p = 1'b0;
    check("restart_from_pause", state, M_IDLE);

    // ---- 6. async reset mid-song ----
    play_or_pause = 1'b1;
    tick();
    wait_tick(20, n);
    wait_tick(20, n);
    check("pre_reset_idx", beat_idx, 2);
    run(1);
    #3;                            // between clock edges
    rst = 1'b1;
    #1;
    model_reset();
    compare_model();
    play_or_pause = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_reset_idle", state, M_IDLE);
    play_or_pause = 1'b1;
    tick();
    check("post_reset_play", state, M_PLAY);

    // ---- randomized ----
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15, 0) == 0) play_or_pause = ~play_or_pause;
      restart_1p = ($urandom_range(40, 0) == 0);
      if ($urandom_range(63, 0) == 0) loop_en = ~loop_en;
      if ($urandom_range(15, 0) == 0) speed = 2'($urandom_range(3, 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
